// File: rtl/sms_trigger_ring.sv
// sms_trigger_ring: one-hot binary-trigger ring driven from open-collector inverter outputs.
// Build option ADV_GLITCH_FILTER_EN adds a minimum-low-width filter on the advance line.
module sms_trigger_ring #(
  parameter int N           = 10,
  parameter int PW          = 4,
  parameter int FILT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          adv_pin,
  input  logic          gate_pin,
  input  logic          dc_reset_pin,
  input  logic          hold_pin,
  output logic [N-1:0]  ring,
  output logic [N-1:0]  ring_n,
  output logic [PW-1:0] pos,
  output logic          wrap_oc
);

  if ((N < 2) || (N > 16) || ((1 << PW) < N) || (FILT_CYCLES < 1)) begin : g_param_check
    $error("sms_trigger_ring: illegal parameter combination");
  end

  // Undriven dotted nets float high; an unknown level is treated as an asserted (low) line.
  function automatic logic f_res(input logic v);
    return (v !== 1'b0) && (v !== 1'bx);
  endfunction

  logic w_adv_in;
  logic w_gate_in;
  logic w_dcr_in;
  logic w_hold_in;

  assign w_adv_in  = f_res(adv_pin);
  assign w_gate_in = f_res(gate_pin);
  assign w_dcr_in  = f_res(dc_reset_pin);
  assign w_hold_in = f_res(hold_pin);

  logic r_adv_s1, r_adv_s2, r_adv_s3;
  logic r_gate_s1, r_gate_s2;
  logic r_dcr_s1, r_dcr_s2;
  logic r_hold_s1, r_hold_s2;
  logic r_adv_v1, r_adv_v2, r_adv_v3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adv_s1  <= 1'b1;
      r_adv_s2  <= 1'b1;
      r_adv_s3  <= 1'b1;
      r_gate_s1 <= 1'b1;
      r_gate_s2 <= 1'b1;
      r_dcr_s1  <= 1'b1;
      r_dcr_s2  <= 1'b1;
      r_hold_s1 <= 1'b1;
      r_hold_s2 <= 1'b1;
    end else begin
      r_adv_s1  <= w_adv_in;
      r_adv_s2  <= r_adv_s1;
      r_adv_s3  <= r_adv_s2;
      r_gate_s1 <= w_gate_in;
      r_gate_s2 <= r_gate_s1;
      r_dcr_s1  <= w_dcr_in;
      r_dcr_s2  <= r_dcr_s1;
      r_hold_s1 <= w_hold_in;
      r_hold_s2 <= r_hold_s1;
    end
  end

  // Tracks which adv stages hold real samples since reset, so a line already low at
  // release is not mistaken for a fresh falling edge against the reset value of s3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adv_v1 <= 1'b0;
      r_adv_v2 <= 1'b0;
      r_adv_v3 <= 1'b0;
    end else begin
      r_adv_v1 <= 1'b1;
      r_adv_v2 <= r_adv_v1;
      r_adv_v3 <= r_adv_v2;
    end
  end

  logic w_adv_edge;
  logic w_adv_fall;

  assign w_adv_edge = r_adv_s3 & ~r_adv_s2 & r_adv_v3;

`ifdef ADV_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_CYCLES + 1);

  logic [FCW-1:0] r_filt_cnt;
  logic           r_filt_ok;
  logic           w_filt_start_ok;

  assign w_filt_start_ok = (r_filt_cnt == '0) ? w_adv_edge : r_filt_ok;
  assign w_adv_fall      = ~r_adv_s2 & (r_filt_cnt == FCW'(FILT_CYCLES - 1)) & w_filt_start_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_cnt <= '0;
      r_filt_ok  <= 1'b0;
    end else if (r_adv_s2) begin
      r_filt_cnt <= '0;
      r_filt_ok  <= 1'b0;
    end else begin
      if (r_filt_cnt != FCW'(FILT_CYCLES)) begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
      if (r_filt_cnt == '0) begin
        r_filt_ok <= w_adv_edge;
      end
    end
  end
`else
  assign w_adv_fall = w_adv_edge;
`endif

  logic [N-1:0] r_ring;
  logic         r_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ring <= N'(1);
      r_wrap <= 1'b0;
    end else if (!r_dcr_s2) begin
      r_ring <= N'(1);
      r_wrap <= 1'b0;
    end else if (!r_hold_s2) begin
      r_wrap <= 1'b0;
    end else if (w_adv_fall && !r_gate_s2) begin
      r_ring <= {r_ring[N-2:0], r_ring[N-1]};
      r_wrap <= r_ring[N-1];
    end else begin
      r_wrap <= 1'b0;
    end
  end

  logic [PW-1:0] w_pos;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ring[i]) begin
        w_pos = w_pos | PW'(i);
      end
    end
  end

  assign ring    = r_ring;
  assign ring_n  = ~r_ring;
  assign pos     = w_pos;
  assign wrap_oc = r_wrap ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_sms_trigger_ring.sv
// Bench for sms_trigger_ring: directed plan plus random pin activity against a position model.
module tb_sms_trigger_ring;

  localparam int N    = 10;
  localparam int PW   = 4;
  localparam int FILT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic adv_en, adv_val, gate_en, gate_val, dcr_en, dcr_val, hold_en, hold_val;

  wire adv_pin_w, gate_pin_w, dcr_pin_w, hold_pin_w;
  assign adv_pin_w  = adv_en  ? adv_val  : 1'bz;
  assign gate_pin_w = gate_en ? gate_val : 1'bz;
  assign dcr_pin_w  = dcr_en  ? dcr_val  : 1'bz;
  assign hold_pin_w = hold_en ? hold_val : 1'bz;
  pullup (adv_pin_w);
  pullup (gate_pin_w);
  pullup (dcr_pin_w);
  pullup (hold_pin_w);

  wire [N-1:0]  ring_w;
  wire [N-1:0]  ring_n_w;
  wire [PW-1:0] pos_w;
  wire          wrap_w;

  sms_trigger_ring #(.N(N), .PW(PW), .FILT_CYCLES(FILT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adv_pin      (adv_pin_w),
    .gate_pin     (gate_pin_w),
    .dc_reset_pin (dcr_pin_w),
    .hold_pin     (hold_pin_w),
    .ring         (ring_w),
    .ring_n       (ring_n_w),
    .pos          (pos_w),
    .wrap_oc      (wrap_w)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int obs_wraps = 0;

  // Model: position as an integer, pin samples kept as a short history (bit3 adv, 2 gate, 1 dcr, 0 hold).
  int         m_pos;
  bit         m_wrap;
  int         m_run;
  bit         m_ok;
  logic [3:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_wrap = 0;
    m_run  = 0;
    m_ok   = 0;
    hist.delete();
  endtask

  task automatic model_step();
    logic [3:0] cur, x2, x3;
    bit v3, fire;
    int n;
    if (!reset_n) begin
      model_reset();
      return;
    end
    cur = {adv_en ? adv_val : 1'b1, gate_en ? gate_val : 1'b1,
           dcr_en ? dcr_val : 1'b1, hold_en ? hold_val : 1'b1};
    n  = hist.size();
    x2 = (n >= 2) ? hist[n-2] : 4'b1111;
    v3 = (n >= 3);
    x3 = v3 ? hist[n-3] : 4'b1111;
    fire = 0;
`ifdef ADV_GLITCH_FILTER_EN
    if (!x2[3]) begin
      if (m_run == 0) m_ok = v3 && x3[3];
      if (m_run < FILT) begin
        m_run++;
        fire = (m_run == FILT) && m_ok;
      end
    end else begin
      m_run = 0;
      m_ok  = 0;
    end
`else
    fire = v3 && x3[3] && !x2[3];
`endif
    m_wrap = 0;
    if (!x2[1]) begin
      m_pos = 0;
    end else if (x2[0] && fire && !x2[2]) begin
      m_wrap = (m_pos == N - 1);
      m_pos  = (m_pos + 1) % N;
    end
    hist.push_back(cur);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic check_all();
    logic [N-1:0] er, ern;
    er = '0;
    er[m_pos] = 1'b1;
    ern = ~er;
    check("ring", 32'(ring_w), 32'(er));
    check("ring_n", 32'(ring_n_w), 32'(ern));
    check("pos", 32'(pos_w), 32'(m_pos));
    check("wrap", 32'(wrap_w === 1'b1), 32'(m_wrap));
    if (wrap_w === 1'b1) obs_wraps++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input int lo, input int hi);
    adv_en  = 1'b1;
    adv_val = 1'b0;
    repeat (lo) cycle();
    adv_val = 1'b1;
    repeat (hi) cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    adv_en = 0; adv_val = 1; gate_en = 0; gate_val = 1;
    dcr_en = 0; dcr_val = 1; hold_en = 0; hold_val = 1;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;

    // All pins floating: ring parked at position 0, wrap line released.
    repeat (20) cycle();
    check("float_pos", 32'(pos_w), 32'd0);

    // Full revolution with the gate open.
    gate_en = 1'b1; gate_val = 1'b0;
    obs_wraps = 0;
    for (int i = 0; i < 10; i++) pulse(3, 3);
    check("wrap_count", 32'(obs_wraps), 32'd1);
    check("rev_pos", 32'(pos_w), 32'd0);

    // DC reset coincident with an advance edge, then held low.
    for (int i = 0; i < 4; i++) pulse(3, 3);
    check("pre_dc_pos", 32'(pos_w), 32'd4);
    dcr_en = 1'b1; dcr_val = 1'b0; adv_val = 1'b0;
    repeat (3) cycle();
    adv_val = 1'b1;
    repeat (3) cycle();
    check("dc_reset_pos", 32'(pos_w), 32'd0);
    pulse(3, 3);
    pulse(3, 3);
    check("dc_block_pos", 32'(pos_w), 32'd0);
    dcr_en = 1'b0;
    repeat (3) cycle();

    // Hold discards a pulse; floating gate blocks advance.
    for (int i = 0; i < 3; i++) pulse(3, 3);
    hold_en = 1'b1; hold_val = 1'b0;
    pulse(3, 3);
    hold_en = 1'b0;
    repeat (2) cycle();
    check("hold_pos", 32'(pos_w), 32'd3);
    pulse(3, 3);
    check("after_hold_pos", 32'(pos_w), 32'd4);
    gate_en = 1'b0;
    pulse(3, 3);
    pulse(3, 3);
    check("gate_float_pos", 32'(pos_w), 32'd4);
    gate_en = 1'b1; gate_val = 1'b0;

    // Asynchronous reset in the middle of a pending advance.
    pulse(3, 3);
    pulse(3, 3);
    check("pre_rst_pos", 32'(pos_w), 32'd6);
    adv_val = 1'b0;
    repeat (2) cycle();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_pos", 32'(pos_w), 32'd0);
    cycle();
    reset_n = 1'b1;
    repeat (6) cycle();
    check("low_at_release_pos", 32'(pos_w), 32'd0);
    adv_val = 1'b1;
    repeat (3) cycle();
    pulse(3, 3);
    check("fresh_edge_pos", 32'(pos_w), 32'd1);

`ifdef ADV_GLITCH_FILTER_EN
    pulse(1, 4);
    check("glitch_pos", 32'(pos_w), 32'd1);
    pulse(3, 3);
    check("filtered_pulse_pos", 32'(pos_w), 32'd2);
`endif

    // Random pin activity, including floating lines.
    for (int i = 0; i < 400; i++) begin
      adv_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) adv_val = ~adv_val;
      gate_en  = ($urandom_range(0, 9) != 0);
      gate_val = ($urandom_range(0, 7) == 0);
      dcr_en   = ($urandom_range(0, 1) == 0);
      dcr_val  = ($urandom_range(0, 19) != 0);
      hold_en  = ($urandom_range(0, 1) == 0);
      hold_val = ($urandom_range(0, 9) != 0);
      cycle();
    end
    adv_en = 0; gate_en = 0; dcr_en = 0; hold_en = 0;
    repeat (5) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sms_trigger_ring.md
Name: sms_trigger_ring

Overview:
- Clocked model of an SMS binary-trigger ring card. Sits directly downstream of the 3-way inverter cards.
- Consumes their outputs, including open-collector dotted nets that float when undriven.
- Advances a one-hot ring one position on each gated falling edge of the advance input.
- Drives its true and complement position lines, plus an open-collector wrap line back into the inverter layer.

Parameters:
- N, 10, number of ring positions (2..16).
- PW, 4, width of the binary position output; must satisfy 2**PW >= N.
- FILT_CYCLES, 2, consecutive low samples needed to accept an advance edge (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- adv_pin  input  1  advance pulse line from an inverter output; floating (z) reads as 1; a falling edge advances the ring.
- gate_pin  input  1  AC gate, active low; floating reads as 1 (gate closed).
- dc_reset_pin  input  1  DC reset, active low; floating reads as 1 (inactive).
- hold_pin  input  1  hold, active low; floating reads as 1 (inactive).
- ring  output  N  one-hot position, true phase.
- ring_n  output  N  bitwise complement of ring.
- pos  output  PW  binary index of the active position.
- wrap_oc  output  1  open collector: drives 1 for one clk when the ring advances from N-1 to 0, otherwise z.

Behaviour:
- Input resolution: every *_pin input is resolved before sampling. 1 or z gives 1; 0 or x gives 0.
- Synchronisers:
  - adv, gate, dc_reset and hold each pass through a 2-flop synchroniser; stage outputs are s1, s2.
  - adv has a third flop, adv_s3, for edge detection.
  - All synchroniser flops reset to 1.
- Advance condition: adv_fall = adv_s3 & ~adv_s2.
- Latency: a falling edge on adv_pin that meets setup before rising edge k changes ring on edge k+2.
  - gate and hold are evaluated on their s2 values in the same cycle as adv_fall.
- Per-cycle priority (highest first):
  - dc_reset_s2 == 0: ring <= 1 (position 0). No wrap pulse.
  - Else hold_s2 == 0: ring unchanged. A coincident adv_fall is discarded, not queued.
  - Else adv_fall & (gate_s2 == 0): ring rotates left by one. Bit N-1 wraps to bit 0.
  - Else: ring unchanged.
- Wrap: wrap_oc = 1 in the cycle after a rotation from position N-1 to 0, for exactly one clk; otherwise z. A dc_reset never produces wrap.
- ring_n always equals ~ring. pos always equals the index of the set bit in ring.
- Reset (reset_n low, asynchronous):
  - ring = 1, ring_n = ~1, pos = 0, wrap_oc = z, all synchroniser and filter state = 1/idle.
  - Reset asserted mid-pulse drops any pending edge.
  - After release, an adv_pin already low does not advance the ring: a fresh 1→0 transition is required.
- One-hot invariant: ring holds exactly one set bit at all times; no reachable state violates it.
- Back-to-back edges: adv must be high for at least one sampled cycle between edges. Each accepted edge advances exactly one position.
- x on any pin resolves to 0 (active). The bench flags x as an error but the RTL does not propagate it.

Optional Feature:
- Macro ADV_GLITCH_FILTER_EN.
- Defined:
  - A counter on adv_s2 counts consecutive 0 samples, saturating at FILT_CYCLES. Any 1 sample clears it.
  - adv_fall fires once, when the counter first reaches FILT_CYCLES and adv_s3 was 1 at pulse start.
  - Lows shorter than FILT_CYCLES cycles are ignored.
  - Latency grows to FILT_CYCLES+1 edges after the first low sample.
- Undefined: no counter; edge detection exactly as in Behaviour; FILT_CYCLES unused.

Test Plan:
- Reset, then all pins floating (z) for 20 clk -> ring = 10'b0000000001, ring_n = 10'b1111111110, pos = 0, wrap_oc = z throughout.
- gate_pin = 0; 10 adv_pin pulses (3 clk low, 3 clk high) -> pos steps 1..9 then 0; ring changes 2 edges after each falling edge; wrap_oc = 1 for exactly one clk after the 10th pulse.
- Advance to pos = 4, then dc_reset_pin = 0 coincident with an adv falling edge -> pos = 0 two edges later; no wrap pulse; holding dc_reset low blocks further pulses.
- pos = 3, hold_pin = 0 during one pulse, then released -> pos stays 3; the next pulse gives pos = 4. With gate_pin floating, pulses leave pos unchanged.
- reset_n pulsed low while adv_pin is low, pos = 6 -> pos = 0 immediately (asynchronously); after release with adv_pin still low, no advance until adv_pin goes high then low.
- With ADV_GLITCH_FILTER_EN and FILT_CYCLES = 2: a 1-clk low glitch -> no advance; a 3-clk low pulse -> exactly one advance.
